// File: rtl/multicycle_control_if.sv
// Unified memory port handshake between the multi-cycle controller and memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_req, output mem_read, output mem_write, input mem_ready);
  modport slave  (input mem_req, input mem_read, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// RV32I multi-cycle control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing
// with a bounded memory wait and a sticky illegal-instruction trap.
module multicycle_control #(
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned IMM_SRC_W   = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  mem,
  input  logic [6:0]            op,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  alu_zero,
  input  logic                  alu_last_bit,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_source,
  output logic                  reg_write,
  output logic                  alu_source,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [IMM_SRC_W-1:0]  imm_source,
  output logic [1:0]            result_source,
  output logic                  illegal_instr
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD, C_STORE, C_R, C_I, C_BRANCH, C_JAL, C_LUI, C_BAD
  } iclass_t;

  state_t           state, state_d;
  iclass_t          cls;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic             req, rd, wr, taken;
  logic             unused_func7;

  assign unused_func7  = ^{func7[6], func7[4:0]};
  assign mem.mem_req   = req;
  assign mem.mem_read  = rd;
  assign mem.mem_write = wr;

  // Opcode classification; op is stable from DECODE onward.
  always_comb begin
    cls = C_BAD;
    case (op)
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_I;
      7'b1100011: cls = C_BRANCH;
      7'b1101111: cls = C_JAL;
      7'b0110111: cls = C_LUI;
      default:    cls = C_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // Next state and per-state outputs; everything held low while in reset.
  always_comb begin
    state_d       = state;
    wait_cnt_d    = '0;
    req           = 1'b0;
    rd            = 1'b0;
    wr            = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    reg_write     = 1'b0;
    alu_source    = 1'b0;
    alu_op        = '0;
    imm_source    = '0;
    result_source = 2'd0;
    illegal_instr = 1'b0;
    taken         = 1'b0;

    if (rst_n) begin
      case (state)
        S_FETCH: begin
          req = 1'b1;
          rd  = 1'b1;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state_d = S_TRAP;
          end else begin
            wait_cnt_d = wait_cnt + CNT_W'(1);
          end
        end

        S_DECODE: state_d = (cls == C_BAD) ? S_TRAP : S_EXECUTE;

        S_EXECUTE: begin
          case (cls)
            C_LOAD: begin
              alu_source = 1'b1;
              state_d    = S_MEMORY;
            end
            C_STORE: begin
              alu_source = 1'b1;
              imm_source = IMM_SRC_W'(1);
              state_d    = S_MEMORY;
            end
            C_R: begin
              alu_op  = ALU_OP_W'({func7[5], func3});
              state_d = S_WRITEBACK;
            end
            C_I: begin
              alu_op     = ALU_OP_W'({(func3 == 3'b101) ? func7[5] : 1'b0, func3});
              alu_source = 1'b1;
              state_d    = S_WRITEBACK;
            end
            C_BRANCH: begin
              imm_source = IMM_SRC_W'(2);
              state_d    = S_FETCH;
              case (func3)
                3'b000: begin alu_op = ALU_OP_W'(4'b1000); taken = alu_zero;      end
                3'b001: begin alu_op = ALU_OP_W'(4'b1000); taken = !alu_zero;     end
                3'b100: begin alu_op = ALU_OP_W'(4'b0010); taken = alu_last_bit;  end
                3'b101: begin alu_op = ALU_OP_W'(4'b0010); taken = !alu_last_bit; end
                3'b110: begin alu_op = ALU_OP_W'(4'b0011); taken = alu_last_bit;  end
                3'b111: begin alu_op = ALU_OP_W'(4'b0011); taken = !alu_last_bit; end
                default: state_d = S_TRAP;
              endcase
              pc_write  = taken;
              pc_source = taken;
            end
            C_JAL: begin
              pc_write      = 1'b1;
              pc_source     = 1'b1;
              reg_write     = 1'b1;
              result_source = 2'd2;
              imm_source    = IMM_SRC_W'(3);
              state_d       = S_FETCH;
            end
            C_LUI: begin
              reg_write     = 1'b1;
              result_source = 2'd3;
              imm_source    = IMM_SRC_W'(4);
              state_d       = S_FETCH;
            end
            default: state_d = S_TRAP;
          endcase
        end

        S_MEMORY: begin
          req = 1'b1;
          rd  = (cls == C_LOAD);
          wr  = (cls == C_STORE);
          if (mem.mem_ready) begin
            state_d = (cls == C_LOAD) ? S_WRITEBACK : S_FETCH;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state_d = S_TRAP;
          end else begin
            wait_cnt_d = wait_cnt + CNT_W'(1);
          end
        end

        S_WRITEBACK: begin
          reg_write     = 1'b1;
          result_source = (cls == C_LOAD) ? 2'd1 : 2'd0;
          state_d       = S_FETCH;
        end

        S_TRAP: illegal_instr = 1'b1;

        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-cycle expected control words
// are queued by the driver and checked by an independent negedge monitor.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_source;
    logic       reg_write;
    logic       alu_source;
    logic [3:0] alu_op;
    logic [2:0] imm_source;
    logic [1:0] result_source;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       alu_zero = 1'b0;
  logic       alu_last_bit = 1'b0;
  logic       ir_write, pc_write, pc_source, reg_write, alu_source, illegal_instr;
  logic [3:0] alu_op;
  logic [2:0] imm_source;
  logic [1:0] result_source;

  logic [6:0] nxt_op = '0;
  logic [2:0] nxt_f3 = '0;
  logic [6:0] nxt_f7 = '0;
  logic       nxt_z = 1'b0;
  logic       nxt_lb = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  ctl_t exp_q[$];
  string name_q[$];
  ctl_t act;

  multicycle_control_if mif ();

  multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mif),
    .op            (op),
    .func3         (func3),
    .func7         (func7),
    .alu_zero      (alu_zero),
    .alu_last_bit  (alu_last_bit),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_source     (pc_source),
    .reg_write     (reg_write),
    .alu_source    (alu_source),
    .alu_op        (alu_op),
    .imm_source    (imm_source),
    .result_source (result_source),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  assign act = {mif.mem_req, mif.mem_read, mif.mem_write, ir_write, pc_write, pc_source,
                reg_write, alu_source, alu_op, imm_source, result_source, illegal_instr};

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  function automatic ctl_t ctl(input logic rq, rd, wr, ir, pw, ps, rw, as,
                               input logic [3:0] aop, input logic [2:0] imm,
                               input logic [1:0] rs, input logic ill);
    ctl_t c;
    c = {rq, rd, wr, ir, pw, ps, rw, as, aop, imm, rs, ill};
    return c;
  endfunction

  ctl_t Z, F1, F0, TR, WB0, WB1;

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    nxt_op = o;
    nxt_f3 = f3;
    nxt_f7 = f7;
  endtask

  // One clock cycle of stimulus plus its expected control word.
  task automatic step(input logic r, input logic rdy, input ctl_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n         = r;
    op            = nxt_op;
    func3         = nxt_f3;
    func7         = nxt_f7;
    alu_zero      = nxt_z;
    alu_last_bit  = nxt_lb;
    mif.mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin : monitor
    ctl_t  e;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.mem_ready = 1'b0;
    Z   = '0;
    F1  = ctl(1,1,0,1,1,0,0,0, 4'h0, 3'd0, 2'd0, 0);
    F0  = ctl(1,1,0,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 0);
    TR  = ctl(0,0,0,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 1);
    WB0 = ctl(0,0,0,0,0,0,1,0, 4'h0, 3'd0, 2'd0, 0);
    WB1 = ctl(0,0,0,0,0,0,1,0, 4'h0, 3'd0, 2'd1, 0);

    instr('0, '0, '0);
    step(0, 1, Z, "reset0");
    step(0, 1, Z, "reset1");

    instr(OP_R, 3'b000, 7'b0000000);
    step(1, 1, F1,  "add_fetch");
    step(1, 1, Z,   "add_decode");
    step(1, 1, Z,   "add_exec");
    step(1, 1, WB0, "add_wb");

    instr(OP_R, 3'b000, 7'b0100000);
    step(1, 1, F1, "sub_fetch");
    step(1, 1, Z,  "sub_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,0, 4'h8, 3'd0, 2'd0, 0), "sub_exec");
    step(1, 1, WB0, "sub_wb");

    instr(OP_LOAD, 3'b010, 7'b0);
    step(1, 1, F1, "lw_fetch");
    step(1, 1, Z,  "lw_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,1, 4'h0, 3'd0, 2'd0, 0), "lw_exec");
    for (int i = 0; i < 3; i++)
      step(1, 0, ctl(1,1,0,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 0), "lw_mem_wait");
    step(1, 1, ctl(1,1,0,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 0), "lw_mem_done");
    step(1, 1, WB1, "lw_wb");

    instr(OP_BR, 3'b001, 7'b0); nxt_z = 1'b0;
    step(1, 1, F1, "bne_t_fetch");
    step(1, 1, Z,  "bne_t_decode");
    step(1, 1, ctl(0,0,0,0,1,1,0,0, 4'h8, 3'd2, 2'd0, 0), "bne_taken_exec");

    nxt_z = 1'b1;
    step(1, 1, F1, "bne_n_fetch");
    step(1, 1, Z,  "bne_n_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,0, 4'h8, 3'd2, 2'd0, 0), "bne_not_taken_exec");

    instr(OP_BR, 3'b111, 7'b0); nxt_z = 1'b0; nxt_lb = 1'b1;
    step(1, 1, F1, "bgeu_fetch");
    step(1, 1, Z,  "bgeu_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,0, 4'h3, 3'd2, 2'd0, 0), "bgeu_not_taken_exec");

    instr(OP_BR, 3'b100, 7'b0);
    step(1, 1, F1, "blt_fetch");
    step(1, 1, Z,  "blt_decode");
    step(1, 1, ctl(0,0,0,0,1,1,0,0, 4'h2, 3'd2, 2'd0, 0), "blt_taken_exec");
    nxt_lb = 1'b0;

    instr(OP_I, 3'b101, 7'b0100000);
    step(1, 1, F1, "srai_fetch");
    step(1, 1, Z,  "srai_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,1, 4'hd, 3'd0, 2'd0, 0), "srai_exec");
    step(1, 1, WB0, "srai_wb");

    instr(OP_I, 3'b000, 7'b0100000);
    step(1, 1, F1, "addi_fetch");
    step(1, 1, Z,  "addi_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,1, 4'h0, 3'd0, 2'd0, 0), "addi_f7_exec");
    step(1, 1, WB0, "addi_wb");

    instr(OP_STORE, 3'b010, 7'b0);
    step(1, 1, F1, "sw_fetch");
    step(1, 1, Z,  "sw_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,1, 4'h0, 3'd1, 2'd0, 0), "sw_exec");
    step(1, 1, ctl(1,0,1,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 0), "sw_mem");

    instr(OP_JAL, 3'b000, 7'b0);
    step(1, 1, F1, "jal_fetch");
    step(1, 1, Z,  "jal_decode");
    step(1, 1, ctl(0,0,0,0,1,1,1,0, 4'h0, 3'd3, 2'd2, 0), "jal_exec");

    instr(OP_LUI, 3'b000, 7'b0);
    step(1, 1, F1, "lui_fetch");
    step(1, 1, Z,  "lui_decode");
    step(1, 1, ctl(0,0,0,0,0,0,1,0, 4'h0, 3'd4, 2'd3, 0), "lui_exec");

    // Ready on the last permitted wait cycle must beat the timeout.
    instr(OP_LOAD, 3'b010, 7'b0);
    step(1, 1, F1, "lw16_fetch");
    step(1, 1, Z,  "lw16_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,1, 4'h0, 3'd0, 2'd0, 0), "lw16_exec");
    for (int i = 0; i < 15; i++)
      step(1, 0, ctl(1,1,0,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 0), "lw16_mem_wait");
    step(1, 1, ctl(1,1,0,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 0), "lw16_ready_at_limit");
    step(1, 1, WB1, "lw16_wb");

    instr(OP_STORE, 3'b010, 7'b0);
    step(1, 1, F1, "swr_fetch");
    step(1, 1, Z,  "swr_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,1, 4'h0, 3'd1, 2'd0, 0), "swr_exec");
    step(1, 0, ctl(1,0,1,0,0,0,0,0, 4'h0, 3'd0, 2'd0, 0), "swr_mem_wait");
    step(0, 0, Z, "swr_reset_cycle");
    instr(OP_LUI, 3'b000, 7'b0);
    step(1, 0, F0, "post_reset_fetch_wait");
    step(1, 1, F1, "post_reset_fetch");
    step(1, 1, Z,  "post_reset_decode");
    step(1, 1, ctl(0,0,0,0,0,0,1,0, 4'h0, 3'd4, 2'd3, 0), "post_reset_lui_exec");

    instr(OP_BAD, 3'b000, 7'b0);
    step(1, 1, F1, "bad_fetch");
    step(1, 1, Z,  "bad_decode");
    step(1, 1, TR, "bad_trap0");
    step(1, 0, TR, "bad_trap1");
    step(1, 1, TR, "bad_trap2");
    step(0, 1, Z,  "bad_reset");

    instr(OP_BR, 3'b010, 7'b0);
    step(1, 1, F1, "br010_fetch");
    step(1, 1, Z,  "br010_decode");
    step(1, 1, ctl(0,0,0,0,0,0,0,0, 4'h0, 3'd2, 2'd0, 0), "br010_exec");
    step(1, 1, TR, "br010_trap");
    step(0, 1, Z,  "br010_reset");

    instr(OP_R, 3'b000, 7'b0);
    for (int i = 0; i < 16; i++)
      step(1, 0, F0, "fetch_timeout_wait");
    step(1, 0, TR, "fetch_timeout_trap0");
    step(1, 1, TR, "fetch_timeout_trap1");
    step(0, 1, Z,  "fetch_timeout_reset");
    step(1, 1, F1, "final_fetch");

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
